// File: rtl/riscv_lsu_mstage_if.sv
// Data-memory bus between the M stage (master modport) and the memory (slave modport).
// Handshake: o_dmem_req is held with every field stable until the cycle i_dmem_gnt=1 accepts it;
// each accepted read returns exactly one i_dmem_rvalid cycle later, carrying i_dmem_rdata.
interface riscv_lsu_mstage_if #(
  parameter int XLEN = 32
);
  localparam int NB = XLEN / 8;

  logic            o_dmem_req;
  logic            o_dmem_we;
  logic [XLEN-1:0] o_dmem_addr;
  logic [NB-1:0]   o_dmem_byte_sel;
  logic [XLEN-1:0] o_dmem_wdata;
  logic            i_dmem_gnt;
  logic            i_dmem_rvalid;
  logic [XLEN-1:0] i_dmem_rdata;

  modport master (
    output o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_byte_sel, o_dmem_wdata,
    input  i_dmem_gnt, i_dmem_rvalid, i_dmem_rdata
  );

  modport slave (
    input  o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_byte_sel, o_dmem_wdata,
    output i_dmem_gnt, i_dmem_rvalid, i_dmem_rdata
  );
endinterface

// File: rtl/riscv_lsu_mstage.sv
// Pipeline memory stage: EX->M register, req/gnt/rvalid data bus FSM, store lanes, load extract, writeback mux.
// Optional macro RISCV_LSU_MISALIGN_TRAP_EN: flag misaligned accesses instead of forcing natural alignment.
module riscv_lsu_mstage #(
  parameter int XLEN = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_validE,
  input  logic              i_flushE,
  input  logic              i_ctrl_reg_wr_enE,
  input  logic              i_ctrl_result_srcE,
  input  logic [1:0]        i_ctrl_mux_selE,
  input  logic              i_ctrl_mem_rd_enE,
  input  logic              i_ctrl_mem_wr_enE,
  input  logic [2:0]        i_ctrl_funct3E,
  input  logic [XLEN-1:0]   i_alu_resultE,
  input  logic [XLEN-1:0]   i_mem_writedataE,
  input  logic [4:0]        i_regfile_rd_addrE,
  input  logic [XLEN-1:0]   i_PCPlus4E,
  input  logic [XLEN-1:0]   i_PCTargetE,
  input  logic [XLEN-1:0]   i_ExtImmE,
  riscv_lsu_mstage_if.master dmem,
  output logic              o_stallM,
  output logic              o_validM,
  output logic              o_ctrl_reg_wr_enM,
  output logic [4:0]        o_regfile_rd_addrM,
  output logic [XLEN-1:0]   o_writeback_dataM,
  output logic              o_misalignM,
  output logic [1:0]        o_dbgStateM
);
  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } lsuState_e;

  typedef struct packed {
    logic            valid;
    logic            regWr;
    logic            resultSrc;
    logic [1:0]      muxSel;
    logic            memRd;
    logic            memWr;
    logic [2:0]      funct3;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] storeData;
    logic [4:0]      rdAddr;
    logic [XLEN-1:0] pcPlus4;
    logic [XLEN-1:0] pcTarget;
    logic [XLEN-1:0] extImm;
    logic            misalign;
  } mReg_t;

  // Encodings without a legal access size for this XLEN are treated as a full-width access.
  function automatic logic accessOk(input logic [2:0] f3, input logic isLoad);
    logic ok;
    ok = 1'b1;
    if (isLoad) begin
      case (f3)
        3'd3, 3'd6: ok = (XLEN == 64);
        3'd7:       ok = 1'b0;
        default:    ok = 1'b1;
      endcase
    end else begin
      ok = (f3[1:0] != 2'd3) || (XLEN == 64);
    end
    return ok;
  endfunction

  function automatic logic [1:0] accessLog2(input logic [2:0] f3, input logic isLoad);
    return accessOk(f3, isLoad) ? f3[1:0] : 2'(OFFW);
  endfunction

  function automatic logic [OFFW-1:0] lowMask(input logic [1:0] lg);
    logic [OFFW-1:0] mask;
    case (lg)
      2'd0:    mask = '0;
      2'd1:    mask = OFFW'(1);
      2'd2:    mask = OFFW'(3);
      default: mask = '1;
    endcase
    return mask;
  endfunction

`ifdef RISCV_LSU_MISALIGN_TRAP_EN
  function automatic logic misaligned(input logic [2:0] f3, input logic isLoad,
                                      input logic [OFFW-1:0] off);
    return accessOk(f3, isLoad) && ((off & lowMask(accessLog2(f3, isLoad))) != '0);
  endfunction
`endif

  lsuState_e state, nextState;
  mReg_t     m, mNext;
  logic      misE;
  logic      memOpE;

`ifdef RISCV_LSU_MISALIGN_TRAP_EN
  assign misE = (i_ctrl_mem_rd_enE | i_ctrl_mem_wr_enE) &
                misaligned(i_ctrl_funct3E, i_ctrl_mem_rd_enE, i_alu_resultE[OFFW-1:0]);
`else
  assign misE = 1'b0;
`endif

  // A trapped misaligned access never reaches the bus.
  assign memOpE = i_validE & ~i_flushE & (i_ctrl_mem_rd_enE | i_ctrl_mem_wr_enE) & ~misE;

  always_comb begin
    mNext           = '0;
    mNext.valid     = i_validE & ~i_flushE;
    mNext.regWr     = i_ctrl_reg_wr_enE;
    mNext.resultSrc = i_ctrl_result_srcE;
    mNext.muxSel    = i_ctrl_mux_selE;
    mNext.memRd     = i_ctrl_mem_rd_enE;
    mNext.memWr     = i_ctrl_mem_wr_enE;
    mNext.funct3    = i_ctrl_funct3E;
    mNext.alu       = i_alu_resultE;
    mNext.storeData = i_mem_writedataE;
    mNext.rdAddr    = i_regfile_rd_addrE;
    mNext.pcPlus4   = i_PCPlus4E;
    mNext.pcTarget  = i_PCTargetE;
    mNext.extImm    = i_ExtImmE;
    mNext.misalign  = misE;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      m <= '0;
    end else if (!o_stallM) begin
      m <= mNext;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= S_IDLE;
    end else begin
      state <= nextState;
    end
  end

  // The stall equation follows directly from the bus phase; whenever it is low the M register captures.
  always_comb begin
    nextState = state;
    o_stallM  = 1'b0;
    case (state)
      S_IDLE: begin
        if (memOpE) nextState = S_REQ;
      end
      S_REQ: begin
        o_stallM = ~(dmem.i_dmem_gnt & m.memWr) | ~m.memWr;
        if (dmem.i_dmem_gnt) begin
          if (m.memWr) nextState = memOpE ? S_REQ : S_IDLE;
          else         nextState = S_WAIT;
        end
      end
      S_WAIT: begin
        o_stallM = ~dmem.i_dmem_rvalid;
        if (dmem.i_dmem_rvalid) nextState = memOpE ? S_REQ : S_IDLE;
      end
      default: nextState = S_IDLE;
    endcase
  end

  logic [1:0]      lgM;
  logic [OFFW-1:0] effOff;
  logic [NB-1:0]   byteSelBase;
  logic [XLEN-1:0] wdataRep;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] loadData;
  logic            reqM;

  assign lgM    = accessLog2(m.funct3, m.memRd);
  assign effOff = m.alu[OFFW-1:0] & ~lowMask(lgM);
  assign reqM   = (state == S_REQ);

  always_comb begin
    byteSelBase = '1;
    wdataRep    = m.storeData;
    case (lgM)
      2'd0: begin
        byteSelBase = NB'(1);
        wdataRep    = {NB{m.storeData[7:0]}};
      end
      2'd1: begin
        byteSelBase = NB'(3);
        wdataRep    = {(NB/2){m.storeData[15:0]}};
      end
      2'd2: begin
        byteSelBase = NB'(15);
        wdataRep    = {(NB/4){m.storeData[31:0]}};
      end
      default: begin
        byteSelBase = '1;
        wdataRep    = m.storeData;
      end
    endcase
  end

  // Bus fields are forced to zero outside the request phase so idle cycles show a quiet bus.
  assign dmem.o_dmem_req      = reqM;
  assign dmem.o_dmem_we       = reqM & m.memWr;
  assign dmem.o_dmem_addr     = reqM ? {m.alu[XLEN-1:OFFW], {OFFW{1'b0}}} : '0;
  assign dmem.o_dmem_byte_sel = reqM ? (byteSelBase << effOff) : '0;
  assign dmem.o_dmem_wdata    = reqM ? wdataRep : '0;

  assign shifted = dmem.i_dmem_rdata >> {effOff, 3'b000};

  always_comb begin
    loadData = shifted;
    case (m.funct3)
      3'd0:    loadData = XLEN'($signed(shifted[7:0]));
      3'd1:    loadData = XLEN'($signed(shifted[15:0]));
      3'd2:    loadData = XLEN'($signed(shifted[31:0]));
      3'd4:    loadData = XLEN'(shifted[7:0]);
      3'd5:    loadData = XLEN'(shifted[15:0]);
      3'd6:    loadData = XLEN'(shifted[31:0]);
      default: loadData = shifted;
    endcase
  end

  always_comb begin
    o_writeback_dataM = m.alu;
    if (m.resultSrc) begin
      o_writeback_dataM = loadData;
    end else begin
      case (m.muxSel)
        2'd0:    o_writeback_dataM = m.alu;
        2'd1:    o_writeback_dataM = m.extImm;
        2'd2:    o_writeback_dataM = m.pcTarget;
        default: o_writeback_dataM = m.pcPlus4;
      endcase
    end
  end

  assign o_validM           = m.valid & ~o_stallM;
  assign o_ctrl_reg_wr_enM  = o_validM & m.regWr & ~m.misalign;
  assign o_regfile_rd_addrM = m.rdAddr;
  assign o_dbgStateM        = state;

`ifdef RISCV_LSU_MISALIGN_TRAP_EN
  assign o_misalignM = o_validM & m.misalign;
`else
  assign o_misalignM = 1'b0;
`endif

endmodule

// File: tb/tb_riscv_lsu_mstage.sv
// Directed bench for riscv_lsu_mstage (XLEN=32): stores, loads, stalls, flush, writeback mux, reset mid-access.
module tb_riscv_lsu_mstage;
  localparam int XLEN = 32;
  localparam int NB   = XLEN / 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            validE, flushE, regWrE, resSrcE, memRdE, memWrE;
  logic [1:0]      muxSelE;
  logic [2:0]      funct3E;
  logic [XLEN-1:0] aluE, wdataE, pcPlus4E, pcTargetE, extImmE;
  logic [4:0]      rdAddrE;
  logic            stallM, validM, regWrM, misalignM;
  logic [4:0]      rdAddrM;
  logic [XLEN-1:0] wbM;
  logic [1:0]      dbgState;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  riscv_lsu_mstage_if #(.XLEN(XLEN)) dmem ();

  riscv_lsu_mstage #(.XLEN(XLEN)) dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_validE           (validE),
    .i_flushE           (flushE),
    .i_ctrl_reg_wr_enE  (regWrE),
    .i_ctrl_result_srcE (resSrcE),
    .i_ctrl_mux_selE    (muxSelE),
    .i_ctrl_mem_rd_enE  (memRdE),
    .i_ctrl_mem_wr_enE  (memWrE),
    .i_ctrl_funct3E     (funct3E),
    .i_alu_resultE      (aluE),
    .i_mem_writedataE   (wdataE),
    .i_regfile_rd_addrE (rdAddrE),
    .i_PCPlus4E         (pcPlus4E),
    .i_PCTargetE        (pcTargetE),
    .i_ExtImmE          (extImmE),
    .dmem               (dmem),
    .o_stallM           (stallM),
    .o_validM           (validM),
    .o_ctrl_reg_wr_enM  (regWrM),
    .o_regfile_rd_addrM (rdAddrM),
    .o_writeback_dataM  (wbM),
    .o_misalignM        (misalignM),
    .o_dbgStateM        (dbgState)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic setE(input logic v, input logic regWr, input logic resSrc, input logic [1:0] mux,
                      input logic rd, input logic wr, input logic [2:0] f3,
                      input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rdA);
    validE  = v;
    regWrE  = regWr;
    resSrcE = resSrc;
    muxSelE = mux;
    memRdE  = rd;
    memWrE  = wr;
    funct3E = f3;
    aluE    = alu;
    wdataE  = wd;
    rdAddrE = rdA;
  endtask

  task automatic clearE();
    setE(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 5'd0);
  endtask

  // Load with immediate grant, rvalid in the waitCycles-th cycle after the request; an ALU op waits in EX.
  task automatic runLoad(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rdata, input logic [31:0] expWb, input int waitCycles);
    setE(1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0, f3, addr, 32'h0, 5'd5);
    cyc();
    setE(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 3'd0, 32'h55, 32'h0, 5'd6);
    dmem.i_dmem_gnt = 1'b1;
    mid();
    chk({tag, "_req"},   32'(dmem.o_dmem_req), 32'h1);
    chk({tag, "_we"},    32'(dmem.o_dmem_we), 32'h0);
    chk({tag, "_addr"},  dmem.o_dmem_addr, {addr[31:2], 2'b00});
    chk({tag, "_stall0"}, 32'(stallM), 32'h1);
    cyc();
    dmem.i_dmem_gnt = 1'b0;
    for (int i = 1; i < waitCycles; i++) begin
      mid();
      chk({tag, "_stallw"}, 32'(stallM), 32'h1);
      chk({tag, "_validw"}, 32'(validM), 32'h0);
      cyc();
    end
    dmem.i_dmem_rvalid = 1'b1;
    dmem.i_dmem_rdata  = rdata;
    mid();
    chk({tag, "_stallr"}, 32'(stallM), 32'h1 - 32'h1);
    chk({tag, "_valid"},  32'(validM), 32'h1);
    chk({tag, "_wb"},     wbM, expWb);
    chk({tag, "_regwr"},  32'(regWrM), 32'h1);
    chk({tag, "_rd"},     32'(rdAddrM), 32'd5);
    cyc();
    dmem.i_dmem_rvalid = 1'b0;
    dmem.i_dmem_rdata  = 32'h0;
    clearE();
    mid();
    chk({tag, "_alu_valid"}, 32'(validM), 32'h1);
    chk({tag, "_alu_wb"},    wbM, 32'h55);
    chk({tag, "_alu_rd"},    32'(rdAddrM), 32'd6);
    cyc();
  endtask

  initial begin
    rst       = 1'b1;
    flushE    = 1'b0;
    pcPlus4E  = 32'h200;
    pcTargetE = 32'h300;
    extImmE   = 32'h400;
    clearE();
    dmem.i_dmem_gnt    = 1'b0;
    dmem.i_dmem_rvalid = 1'b0;
    dmem.i_dmem_rdata  = 32'h0;

    // Reset state
    #2;
    chk("rst_req",   32'(dmem.o_dmem_req), 32'h0);
    chk("rst_stall", 32'(stallM), 32'h0);
    chk("rst_valid", 32'(validM), 32'h0);
    chk("rst_wb",    wbM, 32'h0);
    chk("rst_state", 32'(dbgState), 32'h0);
    mid();
    rst = 1'b0;
    cyc();

    // SW 0x104, same-cycle grant
    setE(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 3'd2, 32'h104, 32'hDEADBEEF, 5'd0);
    cyc();
    clearE();
    dmem.i_dmem_gnt = 1'b1;
    mid();
    chk("sw_req",   32'(dmem.o_dmem_req), 32'h1);
    chk("sw_we",    32'(dmem.o_dmem_we), 32'h1);
    chk("sw_addr",  dmem.o_dmem_addr, 32'h104);
    chk("sw_bsel",  32'(dmem.o_dmem_byte_sel), 32'hF);
    chk("sw_wdata", dmem.o_dmem_wdata, 32'hDEADBEEF);
    chk("sw_stall", 32'(stallM), 32'h0);
    chk("sw_valid", 32'(validM), 32'h1);
    chk("sw_regwr", 32'(regWrM), 32'h0);
    chk("sw_state", 32'(dbgState), 32'h1);
    cyc();
    dmem.i_dmem_gnt = 1'b0;
    mid();
    chk("sw_idle_req", 32'(dmem.o_dmem_req), 32'h0);
    chk("sw_idle_state", 32'(dbgState), 32'h0);
    cyc();

    // SB 0x103
    setE(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 3'd0, 32'h103, 32'h000000A5, 5'd0);
    cyc();
    clearE();
    dmem.i_dmem_gnt = 1'b1;
    mid();
    chk("sb_addr",  dmem.o_dmem_addr, 32'h100);
    chk("sb_bsel",  32'(dmem.o_dmem_byte_sel), 32'h8);
    chk("sb_wdata", dmem.o_dmem_wdata, 32'hA5A5A5A5);
    chk("sb_stall", 32'(stallM), 32'h0);
    cyc();
    dmem.i_dmem_gnt = 1'b0;

    // SH 0x102, grant one cycle late: fields hold while stalled
    setE(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 3'd1, 32'h102, 32'hFFFF1234, 5'd0);
    cyc();
    clearE();
    mid();
    chk("sh_stall",  32'(stallM), 32'h1);
    chk("sh_valid0", 32'(validM), 32'h0);
    chk("sh_bsel",   32'(dmem.o_dmem_byte_sel), 32'hC);
    chk("sh_wdata",  dmem.o_dmem_wdata, 32'h12341234);
    cyc();
    dmem.i_dmem_gnt = 1'b1;
    mid();
    chk("sh_stall_g", 32'(stallM), 32'h0);
    chk("sh_valid",   32'(validM), 32'h1);
    chk("sh_bsel_g",  32'(dmem.o_dmem_byte_sel), 32'hC);
    chk("sh_addr_g",  dmem.o_dmem_addr, 32'h100);
    cyc();
    dmem.i_dmem_gnt = 1'b0;

    // Loads
    runLoad("lb",  3'd0, 32'h102, 32'h0080FF00, 32'hFFFFFF80, 3);
    runLoad("lbu", 3'd4, 32'h102, 32'h0080FF00, 32'h00000080, 3);
    runLoad("lh",  3'd1, 32'h102, 32'h80001234, 32'hFFFF8000, 1);
    runLoad("lhu", 3'd5, 32'h102, 32'h80001234, 32'h00008000, 2);
    runLoad("lw",  3'd2, 32'h100, 32'h12345678, 32'h12345678, 2);

    // Writeback mux selections
    setE(1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 3'd0, 32'h55, 32'h0, 5'd7);
    cyc();
    clearE();
    mid();
    chk("wb_imm", wbM, 32'h400);
    chk("wb_imm_regwr", 32'(regWrM), 32'h1);
    setE(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 3'd0, 32'h55, 32'h0, 5'd7);
    cyc();
    clearE();
    mid();
    chk("wb_pct", wbM, 32'h300);
    setE(1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 3'd0, 32'h55, 32'h0, 5'd7);
    cyc();
    clearE();
    mid();
    chk("wb_pc4", wbM, 32'h200);
    cyc();

    // Flushed store: bubble, no bus request
    setE(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 3'd2, 32'h108, 32'h1, 5'd8);
    flushE = 1'b1;
    cyc();
    flushE = 1'b0;
    clearE();
    mid();
    chk("flush_valid", 32'(validM), 32'h0);
    chk("flush_regwr", 32'(regWrM), 32'h0);
    chk("flush_req",   32'(dmem.o_dmem_req), 32'h0);
    cyc();

    // Back-to-back stores
    setE(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 3'd2, 32'h110, 32'h11112222, 5'd0);
    cyc();
    setE(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 3'd0, 32'h111, 32'h0000005A, 5'd0);
    dmem.i_dmem_gnt = 1'b1;
    mid();
    chk("b2b_first_addr",  dmem.o_dmem_addr, 32'h110);
    chk("b2b_first_stall", 32'(stallM), 32'h0);
    cyc();
    clearE();
    mid();
    chk("b2b_state", 32'(dbgState), 32'h1);
    chk("b2b_bsel",  32'(dmem.o_dmem_byte_sel), 32'h2);
    chk("b2b_wdata", dmem.o_dmem_wdata, 32'h5A5A5A5A);
    cyc();
    dmem.i_dmem_gnt = 1'b0;
    mid();
    chk("b2b_idle_req", 32'(dmem.o_dmem_req), 32'h0);
    cyc();

    // Reset while waiting for read data
    setE(1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 3'd2, 32'h100, 32'h0, 5'd3);
    cyc();
    clearE();
    dmem.i_dmem_gnt = 1'b1;
    cyc();
    dmem.i_dmem_gnt = 1'b0;
    mid();
    chk("rstw_state", 32'(dbgState), 32'h2);
    chk("rstw_stall", 32'(stallM), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("rstw_req_0",   32'(dmem.o_dmem_req), 32'h0);
    chk("rstw_stall_0", 32'(stallM), 32'h0);
    chk("rstw_valid_0", 32'(validM), 32'h0);
    chk("rstw_wb_0",    wbM, 32'h0);
    chk("rstw_state_0", 32'(dbgState), 32'h0);
    mid();
    rst = 1'b0;
    cyc();
    setE(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 3'd0, 32'h77, 32'h0, 5'd9);
    cyc();
    clearE();
    mid();
    chk("post_rst_valid", 32'(validM), 32'h1);
    chk("post_rst_wb",    wbM, 32'h77);
    chk("post_rst_rd",    32'(rdAddrM), 32'd9);
    cyc();

    // LW at 0x102: trapped when the feature is built in, naturally aligned otherwise
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
    setE(1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 3'd2, 32'h102, 32'h0, 5'd10);
    cyc();
    clearE();
    mid();
    chk("mis_flag",  32'(misalignM), 32'h1);
    chk("mis_valid", 32'(validM), 32'h1);
    chk("mis_req",   32'(dmem.o_dmem_req), 32'h0);
    chk("mis_regwr", 32'(regWrM), 32'h0);
    chk("mis_stall", 32'(stallM), 32'h0);
    chk("mis_state", 32'(dbgState), 32'h0);
    cyc();
`else
    setE(1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 3'd2, 32'h102, 32'h0, 5'd10);
    cyc();
    clearE();
    dmem.i_dmem_gnt = 1'b1;
    mid();
    chk("al_flag", 32'(misalignM), 32'h0);
    chk("al_req",  32'(dmem.o_dmem_req), 32'h1);
    chk("al_addr", dmem.o_dmem_addr, 32'h100);
    chk("al_bsel", 32'(dmem.o_dmem_byte_sel), 32'hF);
    cyc();
    dmem.i_dmem_gnt    = 1'b0;
    dmem.i_dmem_rvalid = 1'b1;
    dmem.i_dmem_rdata  = 32'hCAFEF00D;
    mid();
    chk("al_wb",    wbM, 32'hCAFEF00D);
    chk("al_regwr", 32'(regWrM), 32'h1);
    cyc();
    dmem.i_dmem_rvalid = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_lsu_mstage.md
Name: riscv_lsu_mstage

Overview:
- Memory stage for the pipelined core, replacing the single-cycle data-memory path.
- Registers EX→M control and data, and drives a req/gnt/rvalid data-memory bus with variable latency.
- Generates store byte lanes and replicated write data, and extracts plus sign/zero-extends load data.
- Stalls the pipeline while a bus transaction is outstanding, and selects the writeback value.
- Sits between the execute stage and the writeback pipeline register.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64 (64 adds LD/SD/LWU).
NB, XLEN/8, byte lanes (derived; do not override).

Ports:
i_clk  in  1  clock
i_rst  in  1  async reset, active-high
i_validE  in  1  EX instruction valid
i_flushE  in  1  inject bubble into M at next capture
i_ctrl_reg_wr_enE  in  1  register-file write enable
i_ctrl_result_srcE  in  1  1 = load data to writeback
i_ctrl_mux_selE  in  2  writeback select: 0 alu, 1 ExtImm, 2 PCTarget, 3 PCPlus4
i_ctrl_mem_rd_enE  in  1  load
i_ctrl_mem_wr_enE  in  1  store
i_ctrl_funct3E  in  3  access size/sign
i_alu_resultE  in  XLEN  effective address / ALU result
i_mem_writedataE  in  XLEN  store data (rs2)
i_regfile_rd_addrE  in  5  destination register
i_PCPlus4E, i_PCTargetE, i_ExtImmE  in  XLEN  writeback candidates
o_dmem_req  out  1  bus request
o_dmem_we  out  1  bus write
o_dmem_addr  out  XLEN  word-aligned address
o_dmem_byte_sel  out  NB  byte lanes
o_dmem_wdata  out  XLEN  lane-replicated store data
i_dmem_gnt  in  1  request accepted
i_dmem_rvalid  in  1  read data valid
i_dmem_rdata  in  XLEN  read data
o_stallM  out  1  hold IF/ID/EX and this stage
o_validM  out  1  M result valid this cycle
o_ctrl_reg_wr_enM  out  1  gated by o_validM
o_regfile_rd_addrM  out  5  destination register
o_writeback_dataM  out  XLEN  selected writeback value
o_misalignM  out  1  misaligned access (feature only)

Behaviour:
- Reset (async, i_rst=1): M register cleared (valid=0), FSM=IDLE. All outputs 0.
- Capture: M register loads EX inputs on the rising edge when o_stallM=0. The captured valid is i_validE & ~i_flushE. Holds when stalled.
- FSM states IDLE, REQ, WAIT:
  - IDLE→REQ on capture of a valid load/store.
  - REQ: o_dmem_req=1. On i_dmem_gnt: store→IDLE (or REQ again if the next captured instruction is a memory op); load→WAIT.
  - WAIT: on i_dmem_rvalid→IDLE (or REQ for a back-to-back memory op).
  - i_dmem_rvalid outside WAIT is ignored.
- o_stallM = (REQ & ~(gnt & we)) | (REQ & ~we) | (WAIT & ~rvalid).
  - A store with same-cycle gnt costs 0 stalls.
  - A load costs ≥1 stall; minimum is gnt in the REQ cycle and rvalid the next cycle.
- o_validM = M.valid & ~o_stallM. Non-memory instructions complete in the capture-following cycle.
- Bus fields are valid only while o_dmem_req=1 and are held stable until gnt.
- o_dmem_addr = address with low log2(NB) bits zeroed. Offset off = addr[log2(NB)-1:0].
- Stores:
  - SB: byte replicated to all lanes, byte_sel = 1<<off.
  - SH: halfword replicated, byte_sel = 2'b11<<off.
  - SW: byte_sel = 4'hF<<off.
  - SD (XLEN=64): all lanes.
- Loads: shift i_dmem_rdata right by 8*off, then:
  - LB/LH/LW: sign-extend.
  - LBU/LHU/LWU: zero-extend.
  - Unsupported funct3: zero-extend the full word.
- Writeback: result_src=1 → extracted load data, sampled combinationally in the rvalid cycle. Otherwise mux per ctrl_mux_sel.
- Flush never aborts an issued bus transaction; i_flushE only affects the next capture.
- Reset mid-transaction: FSM returns to IDLE immediately. The bus must tolerate a dropped request.

Optional Feature:
- Macro RISCV_LSU_MISALIGN_TRAP_EN.
- Enabled:
  - Halfword with off[0]≠0, word with off[1:0]≠0, or dword with off≠0 → o_misalignM=1 with o_validM.
  - No bus request is issued and reg write is suppressed.
  - FSM stays IDLE; 0 stalls.
- Disabled: o_misalignM tied 0. Low offset bits beyond the access size are ignored (natural alignment forced).

Test Plan:
- SW addr 0x104 data 0xDEADBEEF, gnt same cycle → req=1, we=1, addr 0x104, byte_sel 4'hF, no stall, o_validM next cycle.
- SB addr 0x103 data 0x000000A5 → byte_sel 4'b1000, wdata 0xA5A5A5A5.
- LB addr 0x102, rdata 0x0080FF00, gnt immediate, rvalid after 3 cycles → stall 3 cycles, writeback 0xFFFFFF80. Same sequence as LBU → writeback 0x00000080.
- ALU op (mux_sel=0, alu 0x55) directly after a stalled load → ALU op held in EX during the stall, completes the cycle after the load.
- i_rst asserted while in WAIT → outputs 0 asynchronously; the first instruction after release completes normally.
- Feature on: LW addr 0x102 → o_misalignM=1, req=0, reg_wr_en=0, no stall.
